// File: rtl/tawas_regfile.sv
// tawas_regfile: two-bank (one per thread slice) 8 x 32-bit register file.
// The AU always writes the bank opposite the current slice. A load/store write
// that collides with an AU write on that bank is parked in a one-deep pending
// slot for its bank and drains on the first edge where the AU leaves that bank
// alone. Reads are combinational and forward a pending entry for the read bank.
// Optional feature: define TAWAS_REGFILE_BYPASS_EN to also forward a direct LS
// write that commits to the read bank in the same cycle.
module tawas_regfile (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SLICE,
  input  logic [2:0]  AU_RA_SEL,
  output logic [31:0] AU_RA,
  input  logic [2:0]  AU_RB_SEL,
  output logic [31:0] AU_RB,
  input  logic        AU_RC_VLD,
  input  logic [2:0]  AU_RC_SEL,
  input  logic [31:0] AU_RC,
  input  logic        LS_RC_VLD,
  input  logic        LS_RC_SLICE,
  input  logic [2:0]  LS_RC_SEL,
  input  logic [31:0] LS_RC,
  output logic        LS_RC_RDY
);

  logic [31:0] regs_q      [0:1][0:7];
  logic [1:0]  pend_vld_q;
  logic [2:0]  pend_sel_q  [0:1];
  logic [31:0] pend_data_q [0:1];

  logic        au_bank;
  logic        ls_acc;
  logic        ls_defer;
  logic        ls_direct;
  logic [1:0]  drain;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  // AU result belongs to the previous slice, so it lands in the other bank.
  assign au_bank   = ~SLICE;
  assign LS_RC_RDY = ~pend_vld_q[LS_RC_SLICE];
  assign ls_acc    = LS_RC_VLD & LS_RC_RDY;
  assign ls_defer  = ls_acc & AU_RC_VLD & (LS_RC_SLICE == au_bank);
  assign ls_direct = ls_acc & ~ls_defer;

  // A pending entry drains whenever the AU is not writing its bank this edge.
  assign drain[0] = pend_vld_q[0] & ~(AU_RC_VLD & ~au_bank);
  assign drain[1] = pend_vld_q[1] & ~(AU_RC_VLD &  au_bank);

  // Storage and pending-valid update. Collisions cannot occur: the AU and a
  // direct LS write never share a bank, and a drain or capture on a bank
  // excludes a direct LS write to it (LS_RC_RDY is low while pending).
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          regs_q[b][r] <= 32'h0;
        end
      end
      pend_vld_q <= 2'b00;
    end else begin
      if (AU_RC_VLD) begin
        regs_q[au_bank][AU_RC_SEL] <= AU_RC;
      end
      if (ls_direct) begin
        regs_q[LS_RC_SLICE][LS_RC_SEL] <= LS_RC;
      end
      if (drain[0]) begin
        regs_q[0][pend_sel_q[0]] <= pend_data_q[0];
        pend_vld_q[0]            <= 1'b0;
      end
      if (drain[1]) begin
        regs_q[1][pend_sel_q[1]] <= pend_data_q[1];
        pend_vld_q[1]            <= 1'b0;
      end
      if (ls_defer) begin
        pend_vld_q[LS_RC_SLICE] <= 1'b1;
      end
    end
  end

  // Pending payload: only meaningful while its valid bit is set, so no reset.
  always_ff @(posedge CLK) begin
    if (ls_defer) begin
      pend_sel_q[LS_RC_SLICE]  <= LS_RC_SEL;
      pend_data_q[LS_RC_SLICE] <= LS_RC;
    end
  end

  // Operand A read: storage, overridden by pending entry, then same-cycle LS
  // commit. A drain into the read bank carries the pending data already
  // forwarded, so it needs no separate path.
  always_comb begin
    rd_a = regs_q[SLICE][AU_RA_SEL];
    if (pend_vld_q[SLICE] && (pend_sel_q[SLICE] == AU_RA_SEL)) begin
      rd_a = pend_data_q[SLICE];
    end
`ifdef TAWAS_REGFILE_BYPASS_EN
    if (ls_direct && (LS_RC_SLICE == SLICE) && (LS_RC_SEL == AU_RA_SEL)) begin
      rd_a = LS_RC;
    end
`endif
  end

  // Operand B read: same precedence as operand A.
  always_comb begin
    rd_b = regs_q[SLICE][AU_RB_SEL];
    if (pend_vld_q[SLICE] && (pend_sel_q[SLICE] == AU_RB_SEL)) begin
      rd_b = pend_data_q[SLICE];
    end
`ifdef TAWAS_REGFILE_BYPASS_EN
    if (ls_direct && (LS_RC_SLICE == SLICE) && (LS_RC_SEL == AU_RB_SEL)) begin
      rd_b = LS_RC;
    end
`endif
  end

  assign AU_RA = rd_a;
  assign AU_RB = rd_b;

endmodule

// File: tb/tb_tawas_regfile.sv
// Testbench for tawas_regfile: directed scenarios followed by randomized
// traffic, checked by a queue-based scoreboard against a behavioural model.
module tb_tawas_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SLICE;
  logic [2:0]  AU_RA_SEL, AU_RB_SEL, AU_RC_SEL, LS_RC_SEL;
  logic [31:0] AU_RA, AU_RB, AU_RC, LS_RC;
  logic        AU_RC_VLD, LS_RC_VLD, LS_RC_SLICE, LS_RC_RDY;

  always #5 CLK = ~CLK;

  tawas_regfile dut (
    .CLK(CLK), .RST(RST), .SLICE(SLICE),
    .AU_RA_SEL(AU_RA_SEL), .AU_RA(AU_RA),
    .AU_RB_SEL(AU_RB_SEL), .AU_RB(AU_RB),
    .AU_RC_VLD(AU_RC_VLD), .AU_RC_SEL(AU_RC_SEL), .AU_RC(AU_RC),
    .LS_RC_VLD(LS_RC_VLD), .LS_RC_SLICE(LS_RC_SLICE), .LS_RC_SEL(LS_RC_SEL),
    .LS_RC(LS_RC), .LS_RC_RDY(LS_RC_RDY)
  );

  typedef struct {
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rdy;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;
  logic last_acc = 1'b0;

  // Reference model: architectural state only.
  logic [31:0] m_bank [2][8];
  logic        m_pv   [2];
  logic [2:0]  m_ps   [2];
  logic [31:0] m_pd   [2];

  function automatic logic [31:0] m_read(input logic [2:0] sel);
    logic [31:0] v;
    int s;
    s = int'(SLICE);
    v = m_bank[s][sel];
    if (m_pv[s] && m_ps[s] == sel) v = m_pd[s];
`ifdef TAWAS_REGFILE_BYPASS_EN
    // A direct LS write to the read bank is visible immediately.
    if (LS_RC_VLD && !m_pv[int'(LS_RC_SLICE)] && LS_RC_SLICE == SLICE &&
        LS_RC_SEL == sel) v = LS_RC;
`endif
    return v;
  endfunction

  task automatic m_update();
    int  wb;
    int  ls;
    bit  acc;
    bit  dr[2];
    if (RST) begin
      for (int b = 0; b < 2; b++) begin
        m_pv[b] = 1'b0;
        for (int r = 0; r < 8; r++) m_bank[b][r] = 32'h0;
      end
    end else begin
      wb  = SLICE ? 0 : 1;
      ls  = int'(LS_RC_SLICE);
      acc = LS_RC_VLD && !m_pv[ls];
      for (int b = 0; b < 2; b++) dr[b] = m_pv[b] && !(AU_RC_VLD && wb == b);
      for (int b = 0; b < 2; b++) begin
        if (dr[b]) begin
          m_bank[b][m_ps[b]] = m_pd[b];
          m_pv[b] = 1'b0;
        end
      end
      if (AU_RC_VLD) m_bank[wb][AU_RC_SEL] = AU_RC;
      if (acc) begin
        if (AU_RC_VLD && ls == wb) begin
          m_pv[ls] = 1'b1;
          m_ps[ls] = LS_RC_SEL;
          m_pd[ls] = LS_RC;
        end else begin
          m_bank[ls][LS_RC_SEL] = LS_RC;
        end
      end
    end
  endtask

  task automatic set_in(input logic s, input logic [2:0] ra, input logic [2:0] rb,
                        input logic auv, input logic [2:0] ausel, input logic [31:0] aud,
                        input logic lsv, input logic lss, input logic [2:0] lssel,
                        input logic [31:0] lsd);
    RST = 1'b0; SLICE = s; AU_RA_SEL = ra; AU_RB_SEL = rb;
    AU_RC_VLD = auv; AU_RC_SEL = ausel; AU_RC = aud;
    LS_RC_VLD = lsv; LS_RC_SLICE = lss; LS_RC_SEL = lssel; LS_RC = lsd;
  endtask

  // One clock: publish expectations for the current inputs, then advance.
  task automatic step(input bit check);
    exp_t e;
    #1;
    if (check) begin
      e.ra  = m_read(AU_RA_SEL);
      e.rb  = m_read(AU_RB_SEL);
      e.rdy = !m_pv[int'(LS_RC_SLICE)];
      e.id  = step_id;
      exp_q.push_back(e);
    end
    last_acc = LS_RC_VLD && !m_pv[int'(LS_RC_SLICE)] && !RST;
    step_id++;
    @(posedge CLK);
    m_update();
    #1;
  endtask

  // Monitor: outputs are combinational and valid every cycle; compare at negedge.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (AU_RA !== e.ra) begin
        n_bad++;
        $display("FAIL au_ra step %0d: got %h expected %h", e.id, AU_RA, e.ra);
      end
      n_cmp++;
      if (AU_RB !== e.rb) begin
        n_bad++;
        $display("FAIL au_rb step %0d: got %h expected %h", e.id, AU_RB, e.rb);
      end
      n_cmp++;
      if (LS_RC_RDY !== e.rdy) begin
        n_bad++;
        $display("FAIL ls_rdy step %0d: got %b expected %b", e.id, LS_RC_RDY, e.rdy);
      end
    end
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    step(0);
    step(0);

    // Post-reset read.
    set_in(0, 3, 0, 0, 0, 0, 0, 0, 0, 0); step(1);

    // AU write from slice 1 lands in bank 0; bank 1 untouched.
    set_in(1, 0, 0, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0); step(1);
    set_in(0, 2, 3, 0, 0, 0, 0, 0, 0, 0); step(1);
    set_in(1, 2, 0, 0, 0, 0, 0, 0, 0, 0); step(1);

    // AU and LS collide on bank 0 r5: LS parked, forwarded, then drained.
    set_in(1, 5, 5, 1, 5, 32'hAAAA5555, 1, 0, 5, 32'h1234); step(1);
    set_in(0, 5, 2, 0, 0, 0, 0, 0, 0, 0); step(1);
    set_in(0, 5, 2, 0, 0, 0, 0, 0, 0, 0); step(1);

    // pending[1] held while AU keeps writing bank 1; second request waits.
    set_in(0, 0, 0, 1, 4, 32'h11111111, 1, 1, 6, 32'hCAFE0001); step(1);
    set_in(0, 6, 4, 1, 4, 32'h22222222, 1, 1, 6, 32'hCAFE0002); step(1);
    set_in(1, 6, 4, 0, 0, 0, 1, 1, 6, 32'hCAFE0002); step(1);
    set_in(1, 6, 4, 0, 0, 0, 1, 1, 6, 32'hCAFE0002); step(1);
    set_in(1, 6, 4, 0, 0, 0, 0, 1, 0, 0); step(1);

    // Direct LS write to the read bank, read in the same cycle and after.
    set_in(0, 1, 1, 0, 0, 0, 1, 0, 1, 32'h55); step(1);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step(1);

    // Reset while pending[0] is valid discards it.
    set_in(1, 7, 0, 1, 7, 32'h77, 1, 0, 7, 32'h99); step(1);
    set_in(1, 7, 0, 1, 0, 32'h0, 0, 0, 0, 0); RST = 1'b1; step(1);
    set_in(0, 7, 2, 0, 0, 0, 0, 0, 0, 0); step(1);
    set_in(1, 4, 6, 0, 0, 0, 0, 1, 0, 0); step(1);

    // Randomized traffic; the LS requester holds a refused request.
    LS_RC_VLD = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!LS_RC_VLD || last_acc) begin
        LS_RC_VLD   = 1'($urandom_range(0, 1));
        LS_RC_SLICE = 1'($urandom_range(0, 1));
        LS_RC_SEL   = 3'($urandom_range(0, 3));
        LS_RC       = $urandom;
      end
      SLICE     = 1'($urandom_range(0, 1));
      AU_RA_SEL = 3'($urandom_range(0, 3));
      AU_RB_SEL = 3'($urandom_range(0, 7));
      AU_RC_VLD = 1'($urandom_range(0, 1));
      AU_RC_SEL = 3'($urandom_range(0, 3));
      AU_RC     = $urandom;
      RST       = ($urandom_range(0, 59) == 0);
      step(1);
    end

    RST = 1'b0; LS_RC_VLD = 1'b0; AU_RC_VLD = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
